uart_line_echo: RTL and testbench
=================================

# uart_line_echo

Line-buffered echo stage between the receive and transmit sides of `UART_TOP`. It takes the place of the byte-by-byte echo. Received bytes are collected into a line buffer, with backspace editing and overflow protection. When the terminator byte arrives, the whole line is replayed into the UART transmit FIFO, optionally followed by a line feed. Its rx-side ports connect to `data_out`/`valid_out`/`data_out_sync` and its tx-side ports to `data_in`/`data_in_sync`/`full_in`.

## Interface
- `DEPTH`, 64: line buffer entries. The terminator is included in the count. Minimum 2.
- `TERM`, 8'h0D: line terminator byte.
- `BS`, 8'h08: backspace byte.
- `ADD_LF`, 1: when 1, send 8'h0A after the terminator.
- `clk`  in  1  single clock, rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte, from `UART_TOP.data_out`.
- `rx_valid`  in  1  received byte available, from `valid_out`.
- `rx_ack`  out  1  one-cycle pop pulse, to `data_out_sync`.
- `tx_data`  out  8  byte to transmit, to `data_in`.
- `tx_sync`  out  1  one-cycle push pulse, to `data_in_sync`.
- `tx_full`  in  1  transmit FIFO full, from `full_in`.
- `busy`  out  1  high while a line is being replayed.
- `overflow`  out  1  sticky: at least one byte of the current line was dropped.

## Operation
- State machine with three states: COLLECT, SEND, GAP. Reset state is COLLECT.
- Storage: `DEPTH` x 8 array, write pointer `cnt` (0..`DEPTH`), read pointer `rd`.
- **Accepting a byte (COLLECT):**
  - A byte is accepted in a cycle where `rx_valid`=1 and `rx_ack`=0.
  - `rx_ack` is high the following cycle, for exactly one cycle.
  - `rx_valid` is not sampled while `rx_ack`=1.
- **Classifying an accepted byte, checked in this order:**
  - Byte == `TERM`: store it at `cnt`, `cnt`+1, go to SEND with `rd`=0.
  - Byte == `BS`: if `cnt`>0 then `cnt`-1; if `cnt`==0 do nothing. Never stored.
  - Other byte with `cnt` < `DEPTH`-1: store it, `cnt`+1.
  - Other byte with `cnt` == `DEPTH`-1: drop it and set `overflow`. Still acked. The last slot is reserved, so the terminator always fits.
- **Replaying the line (SEND):**
  - `rx_valid` is ignored and `rx_ack` stays 0. Bytes wait in the UART receive FIFO.
  - If `tx_full`=0: register `tx_data`=buf[`rd`], pulse `tx_sync`, `rd`+1, go to GAP.
  - If `tx_full`=1: hold; no push.
- **GAP (exactly one cycle):** lets `tx_full` update after a push.
  - Return to SEND if bytes remain.
  - If `rd`==`cnt` and `ADD_LF`=1 and the LF is not yet sent, return to SEND and send 8'h0A as the final byte.
  - Otherwise go to COLLECT with `cnt`=0 and `overflow` cleared.
- `busy` = 1 in SEND and GAP.
- `tx_data` holds its last value between pushes.
- Reset values: `rx_ack`=0, `tx_sync`=0, `tx_data`=8'h00, `busy`=0, `overflow`=0, `cnt`=0, `rd`=0, state COLLECT. Buffer contents are not cleared.

## Timing
- **Acknowledge:** `rx_valid` sampled high at edge T gives `rx_ack`=1 during T+1 to T+2, then 0. The next accept is possible at T+2.
- **Line start:** terminator accepted at T gives state SEND from T+1. The first `tx_sync` is at T+2 if `tx_full`=0.
- **Push rate:** `tx_sync` pulses are at least 2 cycles apart, since every push is followed by GAP. A line of N stored bytes takes 2·N cycles (2·(N+1) with LF) when `tx_full` stays 0.
- **`tx_full`:** sampled only in SEND. If it asserts during GAP, the next SEND cycle stalls.
- **Replay to collect:** the first accept for the next line is possible the cycle after the final GAP.
- **Simultaneous events:** `rx_valid` during the final GAP is not accepted until COLLECT is entered.
- **Reset mid-operation:** `n_rst` low forces all outputs to their reset values immediately. A partially sent line is abandoned and no pulse is extended.

## Test plan
- **Basic line, no backpressure:** feed "AB"+8'h0D with `ADD_LF`=1, `tx_full`=0 -> `tx_sync` pulses at T+2, T+4, T+6, T+8 with `tx_data` 8'h41, 8'h42, 8'h0D, 8'h0A. `busy` falls after the last GAP. Each rx byte gets one `rx_ack`.
- **Backspace:** feed "AXB", 8'h08, 8'h08, "C", 8'h0D -> transmitted sequence 8'h41, 8'h43, 8'h0D, 8'h0A. A leading 8'h08 on an empty line produces nothing.
- **Overflow:** with `DEPTH`=4, feed "ABCDE"+8'h0D -> sent "ABC", 8'h0D, 8'h0A. `overflow`=1 from the accept of 'D' until return to COLLECT, then 0.
- **Backpressure:** hold `tx_full`=1 for 10 cycles after the first push -> no `tx_sync` while high. Resumes the cycle after release with no byte lost or duplicated.
- **Blocked receive and reset:** keep `rx_valid`=1 during SEND -> `rx_ack` stays 0. Assert `n_rst`=0 mid-line -> `busy`, `tx_sync`, `rx_ack` are 0 at once. After release, a new "Z"+8'h0D echoes 8'h5A, 8'h0D, 8'h0A.

Source files
------------

// File: rtl/uart_line_echo_if.sv
// Handshake bundle between the UART receive FIFO, the line echo stage and the UART transmit FIFO.
interface uart_line_echo_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ack;
   logic [7:0] tx_data;
   logic       tx_sync;
   logic       tx_full;
   logic       busy;
   logic       overflow;

   // Environment side: provides received bytes and transmit FIFO status.
   modport master (
      output rx_data, rx_valid, tx_full,
      input  rx_ack, tx_data, tx_sync, busy, overflow
   );

   // Echo stage side.
   modport slave (
      input  rx_data, rx_valid, tx_full,
      output rx_ack, tx_data, tx_sync, busy, overflow
   );
endinterface

// File: rtl/uart_line_echo.sv
// Line-buffered echo: collects a line with backspace editing, then replays it
// (plus an optional line feed) into the UART transmit FIFO.
module uart_line_echo #(
   parameter int unsigned DEPTH  = 64,
   parameter logic [7:0]  TERM   = 8'h0D,
   parameter logic [7:0]  BS     = 8'h08,
   parameter bit          ADD_LF = 1'b1
) (
   input logic             clk,
   input logic             n_rst,
   uart_line_echo_if.slave lnk
);

   localparam int unsigned      PTR_W = $clog2(DEPTH + 1);
   localparam int unsigned      IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
   localparam logic [7:0]       LF    = 8'h0A;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      SEND    = 2'd1,
      GAP     = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       line_buf [DEPTH];
   logic [PTR_W-1:0] cnt_q, cnt_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   logic             lf_sent_q, lf_sent_d;
   logic             overflow_q, overflow_d;
   logic             rx_ack_q, rx_ack_d;
   logic             tx_sync_q, tx_sync_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             busy_q, busy_d;
   logic             wr_en_c;

   logic accept_c;
   logic is_term_c;
   logic is_bs_c;
   logic more_c;
   logic lf_due_c;

   // A byte is taken only while collecting and not in the ack cycle of the previous one.
   assign accept_c  = (state_q == COLLECT) && lnk.rx_valid && !rx_ack_q;
   assign is_term_c = (lnk.rx_data == TERM);
   assign is_bs_c   = (lnk.rx_data == BS);
   assign more_c    = (rd_q != cnt_q);
   assign lf_due_c  = ADD_LF && !lf_sent_q;

   // State register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state_q <= COLLECT;
      else        state_q <= state_d;
   end

   // Next-state logic: collect until terminator, then alternate SEND/GAP until drained.
   always_comb begin
      state_d = state_q;
      case (state_q)
         COLLECT: if (accept_c && is_term_c) state_d = SEND;
         SEND:    if (!lnk.tx_full)          state_d = GAP;
         GAP:     state_d = (more_c || lf_due_c) ? SEND : COLLECT;
         default: state_d = COLLECT;
      endcase
   end

   // Output and datapath next values.
   always_comb begin
      cnt_d      = cnt_q;
      rd_d       = rd_q;
      lf_sent_d  = lf_sent_q;
      overflow_d = overflow_q;
      rx_ack_d   = 1'b0;
      tx_sync_d  = 1'b0;
      tx_data_d  = tx_data_q;
      wr_en_c    = 1'b0;
      case (state_q)
         COLLECT: begin
            if (accept_c) begin
               rx_ack_d = 1'b1;
               if (is_term_c) begin
                  // The last slot is kept free, so the terminator always fits.
                  wr_en_c   = 1'b1;
                  cnt_d     = cnt_q + PTR_W'(1);
                  rd_d      = '0;
                  lf_sent_d = 1'b0;
               end else if (is_bs_c) begin
                  if (cnt_q != '0) cnt_d = cnt_q - PTR_W'(1);
               end else if (cnt_q < LAST) begin
                  wr_en_c = 1'b1;
                  cnt_d   = cnt_q + PTR_W'(1);
               end else begin
                  overflow_d = 1'b1;
               end
            end
         end
         SEND: begin
            if (!lnk.tx_full) begin
               tx_sync_d = 1'b1;
               if (more_c) begin
                  tx_data_d = line_buf[IDX_W'(rd_q)];
                  rd_d      = rd_q + PTR_W'(1);
               end else begin
                  tx_data_d = LF;
                  lf_sent_d = 1'b1;
               end
            end
         end
         GAP: begin
            if (!more_c && !lf_due_c) begin
               cnt_d      = '0;
               overflow_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign busy_d = (state_d != COLLECT);

   // Registered outputs and pointers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_q      <= '0;
         rd_q       <= '0;
         lf_sent_q  <= 1'b0;
         overflow_q <= 1'b0;
         rx_ack_q   <= 1'b0;
         tx_sync_q  <= 1'b0;
         tx_data_q  <= 8'h00;
         busy_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         rd_q       <= rd_d;
         lf_sent_q  <= lf_sent_d;
         overflow_q <= overflow_d;
         rx_ack_q   <= rx_ack_d;
         tx_sync_q  <= tx_sync_d;
         tx_data_q  <= tx_data_d;
         busy_q     <= busy_d;
      end
   end

   // Line storage; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en_c) line_buf[IDX_W'(cnt_q)] <= lnk.rx_data;
   end

   assign lnk.rx_ack   = rx_ack_q;
   assign lnk.tx_data  = tx_data_q;
   assign lnk.tx_sync  = tx_sync_q;
   assign lnk.busy     = busy_q;
   assign lnk.overflow = overflow_q;

endmodule

// File: tb/tb_uart_line_echo.sv
// Self-checking bench for uart_line_echo: line-level reference model plus directed literal cases.
module tb_uart_line_echo;

   localparam int unsigned DEPTH = 4;
   localparam logic [7:0]  TERM  = 8'h0D;
   localparam logic [7:0]  BS    = 8'h08;
   localparam logic [7:0]  LF    = 8'h0A;

   logic clk;
   logic n_rst;
   uart_line_echo_if lnk ();

   uart_line_echo #(
      .DEPTH (DEPTH),
      .TERM  (TERM),
      .BS    (BS),
      .ADD_LF(1'b1)
   ) dut (
      .clk  (clk),
      .n_rst(n_rst),
      .lnk  (lnk)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int full_mode = 0;   // 0: never full, 1: random, 2: forced full

   // Reference model state (written only by the compare process)
   logic [7:0] m_line [$];
   logic [7:0] m_exp  [$];
   logic       m_busy = 1'b0;
   logic       m_ovf  = 1'b0;
   logic       m_ack  = 1'b0;
   logic       m_end_pending = 1'b0;
   logic [7:0] last_tx = 8'h00;
   int         log_c [$];
   logic [7:0] log_d [$];
   logic [7:0] exp_seq [$];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
      end
   endtask

   // Transmit FIFO full driver
   initial begin
      lnk.tx_full = 1'b0;
      forever begin
         @(negedge clk);
         case (full_mode)
            1:       lnk.tx_full = ($urandom_range(0, 3) == 0);
            2:       lnk.tx_full = 1'b1;
            default: lnk.tx_full = 1'b0;
         endcase
      end
   end

   // Per-cycle compare against the line model
   initial begin
      logic       s_valid, s_full, s_sync, m_busy_old, accept;
      logic [7:0] s_data;
      forever begin
         @(posedge clk);
         cyc++;
         s_valid    = lnk.rx_valid;
         s_data     = lnk.rx_data;
         s_full     = lnk.tx_full;
         s_sync     = lnk.tx_sync;
         m_busy_old = m_busy;
         #1;
         if (!n_rst) begin
            m_line.delete();
            m_exp.delete();
            m_busy = 1'b0;
            m_ovf  = 1'b0;
            m_ack  = 1'b0;
            m_end_pending = 1'b0;
            last_tx = 8'h00;
         end else begin
            accept = s_valid && !m_ack && !m_busy_old;
            chk("rx_ack", 32'(lnk.rx_ack), 32'(accept));
            m_ack = accept;
            if (m_end_pending) begin
               m_busy = 1'b0;
               m_ovf  = 1'b0;
               m_end_pending = 1'b0;
            end
            if (accept) begin
               if (s_data == TERM) begin
                  foreach (m_line[i]) m_exp.push_back(m_line[i]);
                  m_exp.push_back(TERM);
                  m_exp.push_back(LF);
                  m_line.delete();
                  m_busy = 1'b1;
               end else if (s_data == BS) begin
                  if (m_line.size() > 0) void'(m_line.pop_back());
               end else if (m_line.size() < DEPTH - 1) begin
                  m_line.push_back(s_data);
               end else begin
                  m_ovf = 1'b1;
               end
            end
            if (lnk.tx_sync) begin
               chk("push_while_full", 32'(s_full), 32'd0);
               chk("push_spacing", 32'(s_sync), 32'd0);
               log_c.push_back(cyc);
               log_d.push_back(lnk.tx_data);
               if (m_exp.size() == 0) begin
                  chk("unexpected_push", 32'(lnk.tx_data), 32'hFFFF_FFFF);
               end else begin
                  chk("tx_data", 32'(lnk.tx_data), 32'(m_exp.pop_front()));
                  if (m_exp.size() == 0) m_end_pending = 1'b1;
               end
               last_tx = lnk.tx_data;
            end else begin
               chk("tx_data_hold", 32'(lnk.tx_data), 32'(last_tx));
            end
            chk("busy", 32'(lnk.busy), 32'(m_busy));
            chk("overflow", 32'(lnk.overflow), 32'(m_ovf));
         end
      end
   end

   // Present a byte and wait until it is acknowledged; rx_valid is left high.
   task automatic send_byte(input logic [7:0] b, output int acc);
      bit ok;
      ok  = 1'b0;
      acc = -1;
      @(negedge clk);
      lnk.rx_data  = b;
      lnk.rx_valid = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #2;
         if (lnk.rx_ack) begin
            ok  = 1'b1;
            acc = cyc;
            break;
         end
      end
      if (!ok) chk("accept_timeout", 32'(b), 32'hFFFF_FFFF);
   endtask

   task automatic release_rx();
      @(negedge clk);
      lnk.rx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk);
         #2;
         if (!m_busy && m_exp.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("idle_timeout", 32'(m_exp.size()), 32'd0);
   endtask

   task automatic wait_pushes(input int n);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #2;
         if (log_d.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("push_timeout", 32'(log_d.size()), 32'(n));
   endtask

   // Compare pushes logged from index lb against exp_seq
   task automatic check_seq(input string nm, input int lb);
      chk({nm, "_count"}, 32'(log_d.size() - lb), 32'(exp_seq.size()));
      foreach (exp_seq[i]) begin
         if (lb + i < log_d.size()) chk({nm, "_byte"}, 32'(log_d[lb + i]), 32'(exp_seq[i]));
         else                       chk({nm, "_byte"}, 32'hFFFF_FFFF, 32'(exp_seq[i]));
      end
   endtask

   initial begin
      int t, lb, p, len;
      logic [7:0] b;
      n_rst        = 1'b0;
      lnk.rx_valid = 1'b0;
      lnk.rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(lnk.busy), 32'd0);
      chk("rst_tx_sync", 32'(lnk.tx_sync), 32'd0);
      chk("rst_rx_ack", 32'(lnk.rx_ack), 32'd0);
      chk("rst_tx_data", 32'(lnk.tx_data), 32'h00);
      chk("rst_overflow", 32'(lnk.overflow), 32'd0);
      n_rst = 1'b1;
      repeat (2) @(negedge clk);

      // Basic line "AB\r": pushes 1,3,5,7 samples after the terminator accept
      lb = log_d.size();
      send_byte(8'h41, t);
      send_byte(8'h42, t);
      send_byte(TERM, t);
      release_rx();
      wait_idle();
      exp_seq = '{8'h41, 8'h42, 8'h0D, 8'h0A};
      check_seq("basic", lb);
      for (int i = 0; i < 4; i++)
         if (lb + i < log_c.size()) chk("basic_push_cycle", 32'(log_c[lb + i] - t), 32'(1 + 2 * i));

      // Backspace editing
      lb = log_d.size();
      send_byte(8'h41, t);
      send_byte(8'h58, t);
      send_byte(8'h42, t);
      send_byte(BS, t);
      send_byte(BS, t);
      send_byte(8'h43, t);
      send_byte(TERM, t);
      release_rx();
      wait_idle();
      exp_seq = '{8'h41, 8'h43, 8'h0D, 8'h0A};
      check_seq("backspace", lb);

      // Backspace on empty line
      lb = log_d.size();
      send_byte(BS, t);
      release_rx();
      repeat (6) @(negedge clk);
      chk("empty_bs_pushes", 32'(log_d.size() - lb), 32'd0);
      chk("empty_bs_busy", 32'(lnk.busy), 32'd0);

      // Overflow with DEPTH=4
      lb = log_d.size();
      send_byte(8'h41, t);
      send_byte(8'h42, t);
      send_byte(8'h43, t);
      chk("ovf_before_d", 32'(lnk.overflow), 32'd0);
      send_byte(8'h44, t);
      chk("ovf_at_d", 32'(lnk.overflow), 32'd1);
      send_byte(8'h45, t);
      send_byte(TERM, t);
      release_rx();
      wait_idle();
      exp_seq = '{8'h41, 8'h42, 8'h43, 8'h0D, 8'h0A};
      check_seq("overflow", lb);
      chk("ovf_cleared", 32'(lnk.overflow), 32'd0);

      // Backpressure: full for 10 cycles right after the first push
      lb = log_d.size();
      send_byte(8'h50, t);
      send_byte(8'h51, t);
      send_byte(TERM, t);
      release_rx();
      wait_pushes(lb + 1);
      p = (log_c.size() > lb) ? log_c[lb] : 0;
      full_mode = 2;
      repeat (10) @(posedge clk);
      #2 full_mode = 0;
      wait_idle();
      exp_seq = '{8'h50, 8'h51, 8'h0D, 8'h0A};
      check_seq("backpressure", lb);
      if (log_c.size() > lb + 1) chk("bp_resume_cycle", 32'(log_c[lb + 1] - p), 32'd11);

      // Blocked receive during replay, then reset mid-line while tx_sync is high
      lb = log_d.size();
      send_byte(8'h4C, t);
      send_byte(8'h4D, t);
      send_byte(TERM, t);
      @(negedge clk);
      lnk.rx_data = 8'h58;
      wait_pushes(lb + 3);
      chk("pre_reset_sync", 32'(lnk.tx_sync), 32'd1);
      n_rst = 1'b0;
      lnk.rx_valid = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(lnk.busy), 32'd0);
      chk("mid_rst_tx_sync", 32'(lnk.tx_sync), 32'd0);
      chk("mid_rst_rx_ack", 32'(lnk.rx_ack), 32'd0);
      chk("mid_rst_tx_data", 32'(lnk.tx_data), 32'h00);
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      lb = log_d.size();
      send_byte(8'h5A, t);
      send_byte(TERM, t);
      release_rx();
      wait_idle();
      exp_seq = '{8'h5A, 8'h0D, 8'h0A};
      check_seq("after_reset", lb);

      // Randomized lines with random backpressure
      full_mode = 1;
      for (int ln = 0; ln < 40; ln++) begin
         len = $urandom_range(0, 7);
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 4) == 0) b = BS;
            else                           b = 8'(8'h20 + $urandom_range(0, 94));
            send_byte(b, t);
            if ($urandom_range(0, 2) == 0) begin
               release_rx();
               repeat ($urandom_range(1, 3)) @(negedge clk);
            end
         end
         send_byte(TERM, t);
         if ($urandom_range(0, 1) == 0) release_rx();
      end
      release_rx();
      wait_idle();
      full_mode = 0;
      repeat (4) @(negedge clk);
      chk("final_drain", 32'(m_exp.size()), 32'd0);
      chk("final_busy", 32'(lnk.busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
